approx_mult_pipe: RTL and testbench

- Parametrised, pipelined N×N unsigned multiplier with a run-time selectable mode per operation.
- Exact mode returns the full product. Approximate mode makes the low APPROX_COLS product columns carry-free, the next-generation form of the 4×4 carry-dropping multiplier.
- Sits between operand producers and accumulation/filter logic behind valid/ready handshakes on both sides.
- Keeps a saturating count of approximate operations issued, for error-budget monitoring.

---
 rtl/approx_mult_pipe.sv | 72 +++++++
 tb/tb_approx_mult_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: pipelined NxN unsigned multiplier with per-beat exact / carry-free-low-columns mode
module approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4,
  parameter int LATENCY     = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_mode,
  output logic [CNT_W-1:0]   approx_cnt,
  input  logic               approx_cnt_clr
);
  localparam int PW = 2 * WIDTH;
  logic          w_stall, w_acc;
  logic [PW-1:0] w_hi, w_lo, w_prod;
  logic          r_v [LATENCY];
  logic [PW-1:0] r_p [LATENCY];
  logic          r_m [LATENCY];
  logic [CNT_W-1:0] r_cnt;
  // low columns collapse to an OR of their partial products; upper columns add normally
  always_comb begin
    w_hi = '0;
    w_lo = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if (i + j < APPROX_COLS) w_lo = w_lo | (PW'(in_a[i] & in_b[j]) << (i + j));
        else w_hi = w_hi + (PW'(in_a[i] & in_b[j]) << (i + j));
    w_prod = in_mode ? (w_hi | w_lo) : PW'(in_a) * PW'(in_b);
  end
  assign w_stall  = r_v[LATENCY-1] & ~out_ready;
  assign in_ready = ~w_stall & ~rst;
  assign w_acc    = in_valid & in_ready;
  // data registers load only behind a valid beat so the output holds between results
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_v[k] <= 1'b0;
        r_p[k] <= '0;
        r_m[k] <= 1'b0;
      end
    end else if (!w_stall) begin
      r_v[0] <= w_acc;
      if (w_acc) begin
        r_p[0] <= w_prod;
        r_m[0] <= in_mode;
      end
      for (int k = 1; k < LATENCY; k++) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k-1]) begin
          r_p[k] <= r_p[k-1];
          r_m[k] <= r_m[k-1];
        end
      end
    end
  end
  always_ff @(posedge clk)
    r_cnt <= (rst | approx_cnt_clr) ? '0 :
             (w_acc & in_mode & ~&r_cnt) ? r_cnt + 1'b1 : r_cnt;
  assign out_valid  = r_v[LATENCY-1];
  assign out_prod   = r_p[LATENCY-1];
  assign out_mode   = r_m[LATENCY-1];
  assign approx_cnt = r_cnt;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: table vectors, directed corner sequences and a random scoreboard run
module tb_approx_mult_pipe;
  localparam int W = 8;
  localparam int K = 4;
  localparam int L = 2;
  logic clk = 1'b0;
  logic rst, in_valid, in_mode, out_ready, approx_cnt_clr;
  logic [W-1:0] in_a, in_b;
  logic in_ready, out_valid, out_mode;
  logic [2*W-1:0] out_prod;
  logic [15:0] approx_cnt;
  logic in_ready4, out_valid4, out_mode4;
  logic [2*W-1:0] out_prod4;
  logic [3:0] cnt4;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(K), .LATENCY(L), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_mode(out_mode), .approx_cnt(approx_cnt), .approx_cnt_clr(approx_cnt_clr));
  approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(K), .LATENCY(L), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b),
    .in_mode(in_mode), .out_valid(out_valid4), .out_ready(out_ready), .out_prod(out_prod4),
    .out_mode(out_mode4), .approx_cnt(cnt4), .approx_cnt_clr(approx_cnt_clr));
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // exact product minus the carries the low columns would have produced, plus their OR bits
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic m);
    int ex, lows, lowor, n;
    ex = int'(a) * int'(b);
    if (!m) return 16'(ex);
    lows = 0;
    lowor = 0;
    for (int c = 0; c < K; c++) begin
      n = 0;
      for (int i = 0; i < W; i++)
        if (c - i >= 0 && c - i < W && a[i] && b[c-i]) n++;
      lows += n << c;
      if (n > 0) lowor |= 1 << c;
    end
    return 16'(ex - lows) | 16'(lowor);
  endfunction
  typedef struct { logic [15:0] p; logic m; int cy; int st; } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, stalls = 0, m_cnt = 0, m_cnt4 = 0;
  bit prev_rst = 0, prev_stall = 0, st;
  logic [15:0] last_p = '0, held_p = '0;
  logic last_m = 1'b0, held_m = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk(!out_valid, "rst_valid", out_valid, 0);
      chk(out_prod == 0 && !out_mode, "rst_prod", out_prod, 0);
      chk(approx_cnt == 0 && cnt4 == 0, "rst_cnt", approx_cnt, 0);
    end
    if (rst) begin
      q.delete();
      m_cnt = 0;
      m_cnt4 = 0;
      last_p = '0;
      last_m = 1'b0;
      prev_stall = 0;
    end else begin
      if (prev_stall) chk(out_valid && out_prod == held_p && out_mode == held_m, "stall_hold", out_prod, held_p);
      if (out_valid) begin
        if (q.size() == 0) chk(0, "spurious_beat", out_prod, 0);
        else if (out_ready) begin
          e = q.pop_front();
          chk(out_prod == e.p, "prod", out_prod, e.p);
          chk(out_mode == e.m, "mode", out_mode, e.m);
          chk(cyc - e.cy == L + stalls - e.st, "latency", cyc - e.cy, L + stalls - e.st);
          last_p = e.p;
          last_m = e.m;
        end
      end else chk(out_prod == last_p && out_mode == last_m, "idle_hold", out_prod, last_p);
      st = out_valid && !out_ready;
      chk(in_ready == !st, "in_ready", in_ready, !st);
      chk(approx_cnt == 16'(m_cnt), "cnt16", approx_cnt, m_cnt);
      chk(cnt4 == 4'(m_cnt4), "cnt4", cnt4, m_cnt4);
      if (st) stalls++;
      prev_stall = st;
      held_p = out_prod;
      held_m = out_mode;
      if (in_valid && in_ready) q.push_back('{ref_prod(in_a, in_b, in_mode), in_mode, cyc, stalls});
      if (approx_cnt_clr) begin
        m_cnt = 0;
        m_cnt4 = 0;
      end else if (in_valid && in_ready && in_mode) begin
        m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_cnt4 = (m_cnt4 == 15) ? m_cnt4 : m_cnt4 + 1;
      end
    end
    prev_rst = rst;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk(q.size() == 0 && !out_valid, "drain", q.size(), 0);
  endtask
  typedef struct { logic [7:0] a; logic [7:0] b; logic m; logic [15:0] p; } vec_t;
  vec_t tbl[8];
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, na;
    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'hFF, 8'hFF, 1'b1, 16'hFDDF};
    tbl[2] = '{8'h03, 8'h03, 1'b1, 16'd7};
    tbl[3] = '{8'h03, 8'h05, 1'b1, 16'd15};
    tbl[4] = '{8'h03, 8'h03, 1'b0, 16'd9};
    tbl[5] = '{8'h0F, 8'h0F, 1'b1, 16'h00BF};
    tbl[6] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[7] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1; approx_cnt_clr = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    na = 0;
    foreach (tbl[v]) begin
      in_a = tbl[v].a; in_b = tbl[v].b; in_mode = tbl[v].m; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      na += int'(tbl[v].m);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 10);
      chk(out_valid && lat == L, "tbl_latency", lat, L);
      chk(out_prod == tbl[v].p, "tbl_prod", out_prod, tbl[v].p);
      chk(out_mode == tbl[v].m, "tbl_mode", out_mode, tbl[v].m);
      chk(approx_cnt == 16'(na), "tbl_cnt", approx_cnt, na);
      tick();
    end
    approx_cnt_clr = 1'b1; tick(); approx_cnt_clr = 1'b0;
    for (int k = 0; k < 256; k++) begin
      in_a = 8'(k); in_b = 8'($urandom); in_mode = k[0]; in_valid = 1'b1;
      tick();
    end
    drain();
    @(negedge clk);
    chk(approx_cnt == 16'd128, "stream_cnt", approx_cnt, 128);
    chk(cnt4 == 4'd15, "stream_cnt4", cnt4, 15);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom); in_valid = 1'b1;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(!in_ready && out_valid, "bp_ready", in_ready, 0);
    end
    tick();
    drain();
    in_a = 8'h11; in_b = 8'h22; in_mode = 1'b1; in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk(!out_valid && approx_cnt == 0, "midrst", out_valid, 0);
    repeat (5) tick();
    approx_cnt_clr = 1'b1; tick(); approx_cnt_clr = 1'b0;
    in_mode = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk(cnt4 == 4'd15, "sat4", cnt4, 15);
    chk(approx_cnt == 16'd20, "cnt20", approx_cnt, 20);
    tick();
    in_valid = 1'b1; in_mode = 1'b1; approx_cnt_clr = 1'b1;
    tick();
    in_valid = 1'b0; approx_cnt_clr = 1'b0;
    @(negedge clk);
    chk(cnt4 == 0 && approx_cnt == 0, "clr_prio", approx_cnt, 0);
    tick();
    drain();
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
      approx_cnt_clr = ($urandom % 50) == 0;
      tick();
    end
    approx_cnt_clr = 1'b0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
